lc4_cmp_pipe: RTL and testbench

Parametrised, pipelined comparator for the LC4 datapath and its wider-word variants. Executes all four compare modes (CMP, CMPU, CMPI, CMPIU) on a selectable operand width behind a valid/ready handshake. Produces the canonical +1 / 0 / −1 result plus NZP flags, two cycles after acceptance. Sits between the decode/issue stage and the writeback/NZP-update logic, and fully tolerates downstream backpressure.

---
 rtl/lc4_cmp_pipe.sv | 143 ++++++++++++++
 tb/tb_lc4_cmp_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc4_cmp_pipe.sv
// rtl/lc4_cmp_pipe.sv - two-stage LC4 CMP/CMPU/CMPI/CMPIU comparator with valid/ready flow control
// S1 captures A, the selected second operand and signedness; S2 holds the +1/0/-1 result and NZP.
module lc4_cmp_pipe #(
  parameter int W     = 16,
  parameter int IMM_W = 7,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [IMM_W-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [2:0]       out_nzp,
  output logic [CNT_W-1:0] done_count
);

  localparam logic [W-1:0]     RES_GT  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1_valid_q, s1_valid_d;
  logic             s1_signed_q, s1_signed_d;
  logic [W-1:0]     s1_a_q, s1_a_d;
  logic [W-1:0]     s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     s2_result_q, s2_result_d;
  logic [2:0]       s2_nzp_q, s2_nzp_d;
  logic [CNT_W-1:0] done_q, done_d;

  logic             s2_advance;
  logic             s1_load;
  logic             accept;
  logic             out_fire;
  logic [W-1:0]     opnd_b;
  logic             cmp_lt;
  logic             cmp_eq;
  logic [W-1:0]     cmp_result;
  logic [2:0]       cmp_nzp;

  // S1 may refill in the same cycle S2 drains, so a full pipe still streams.
  assign s2_advance = !s2_valid_q || out_ready;
  assign s1_load    = !s1_valid_q || s2_advance;
  assign in_ready   = !rst && s1_load;
  assign accept     = in_valid && in_ready;
  assign out_fire   = s2_valid_q && out_ready;

  always_comb begin
    opnd_b = in_b;
    if (in_mode[1]) begin
      if (in_mode[0]) begin
        opnd_b = {{(W-IMM_W){1'b0}}, in_imm};
      end else begin
        opnd_b = {{(W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
      end
    end
  end

  always_comb begin
    cmp_eq = (s1_a_q == s1_b_q);
    if (s1_signed_q) begin
      cmp_lt = ($signed(s1_a_q) < $signed(s1_b_q));
    end else begin
      cmp_lt = (s1_a_q < s1_b_q);
    end
  end

  always_comb begin
    cmp_result = RES_GT;
    cmp_nzp    = 3'b001;
    if (cmp_lt) begin
      cmp_result = '1;
      cmp_nzp    = 3'b100;
    end else if (cmp_eq) begin
      cmp_result = '0;
      cmp_nzp    = 3'b010;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_signed_d = s1_signed_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_nzp_d    = s2_nzp_q;
    done_d      = done_q;

    if (s1_load) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_signed_d = !in_mode[0];
        s1_a_d      = in_a;
        s1_b_d      = opnd_b;
      end
    end

    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = cmp_result;
        s2_nzp_d    = cmp_nzp;
      end
    end

    if (out_fire && (done_q != '1)) begin
      done_d = done_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_signed_q <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_nzp_q    <= 3'b000;
      done_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_signed_q <= s1_signed_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_nzp_q    <= s2_nzp_d;
      done_q      <= done_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_nzp    = s2_nzp_q;
  assign done_count = done_q;

endmodule

// File: tb/tb_lc4_cmp_pipe.sv
// tb/tb_lc4_cmp_pipe.sv - bench for lc4_cmp_pipe
// Directed table, scoreboard against an integer reference model, and multi-cycle corner sequences.
module tb_lc4_cmp_pipe;
  localparam int W     = 16;
  localparam int IMM_W = 7;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [IMM_W-1:0] in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic [2:0]       out_nzp;
  logic [CNT_W-1:0] done_count;

  lc4_cmp_pipe #(.W(W), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_nzp    (out_nzp),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [2:0]   nzp;
    int           acc;
  } exp_t;

  typedef struct {
    logic [1:0]       m;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [IMM_W-1:0] imm;
    logic [W-1:0]     res;
    logic [2:0]       nzp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_out = 0;
  exp_t sb[$];
  int   lat_log[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] m, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [IMM_W-1:0] imm);
    longint va, vb;
    exp_t   e;
    va = longint'(a);
    vb = m[1] ? longint'(imm) : longint'(b);
    if (!m[0]) begin
      if (va >= (longint'(1) << (W-1))) va = va - (longint'(1) << W);
      if (m[1]) begin
        if (vb >= (longint'(1) << (IMM_W-1))) vb = vb - (longint'(1) << IMM_W);
      end else if (vb >= (longint'(1) << (W-1))) begin
        vb = vb - (longint'(1) << W);
      end
    end
    e.acc = 0;
    if (va < vb) begin
      e.res = {W{1'b1}};
      e.nzp = 3'b100;
    end else if (va == vb) begin
      e.res = '0;
      e.nzp = 3'b010;
    end else begin
      e.res = {{(W-1){1'b0}}, 1'b1};
      e.nzp = 3'b001;
    end
    return e;
  endfunction

  // Handshakes are observed mid-cycle; each one completes on the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stale_output: got result 0x%0h with no request outstanding", out_result);
        end else begin
          mon_e = sb.pop_front();
          check("sb_result", out_result, mon_e.res);
          check("sb_nzp", out_nzp, mon_e.nzp);
          lat_log.push_back(cyc - mon_e.acc);
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        mon_e     = model(in_mode, in_a, in_b, in_imm);
        mon_e.acc = cyc;
        sb.push_back(mon_e);
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [IMM_W-1:0] imm, output int waits);
    waits    = 0;
    in_mode  = m;
    in_a     = a;
    in_b     = b;
    in_imm   = imm;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(output int waits);
    logic [1:0]       m;
    logic [W-1:0]     a, b;
    logic [IMM_W-1:0] imm;
    m   = 2'($urandom_range(0, 3));
    a   = W'($urandom);
    b   = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
    imm = IMM_W'($urandom);
    send(m, a, b, imm, waits);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 400) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results still outstanding, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t             tbl[10];
  vec_t             bp[4];
  int               w, wsum, t, idx, base, nbad, cnt;
  logic [3:0]       rdy_log;
  logic [W-1:0]     held;

  initial begin
    tbl[0] = '{2'b00, 16'hFFFF, 16'h0001, 7'h00, 16'hFFFF, 3'b100};
    tbl[1] = '{2'b01, 16'hFFFF, 16'h0001, 7'h00, 16'h0001, 3'b001};
    tbl[2] = '{2'b00, 16'h8000, 16'h8000, 7'h00, 16'h0000, 3'b010};
    tbl[3] = '{2'b10, 16'hFFFF, 16'h1234, 7'h7F, 16'h0000, 3'b010};
    tbl[4] = '{2'b11, 16'hFFFF, 16'h1234, 7'h7F, 16'h0001, 3'b001};
    tbl[5] = '{2'b11, 16'h0005, 16'hFFFF, 7'h06, 16'hFFFF, 3'b100};
    tbl[6] = '{2'b00, 16'h7FFF, 16'h8000, 7'h00, 16'h0001, 3'b001};
    tbl[7] = '{2'b01, 16'h7FFF, 16'h8000, 7'h00, 16'hFFFF, 3'b100};
    tbl[8] = '{2'b10, 16'h0000, 16'h0000, 7'h40, 16'h0001, 3'b001};
    tbl[9] = '{2'b11, 16'h0040, 16'h0000, 7'h40, 16'h0000, 3'b010};
    bp[0]  = '{2'b00, 16'h0003, 16'h0009, 7'h00, 16'h0000, 3'b000};
    bp[1]  = '{2'b01, 16'h9000, 16'h0009, 7'h00, 16'h0000, 3'b000};
    bp[2]  = '{2'b10, 16'h0020, 16'h0000, 7'h20, 16'h0000, 3'b000};
    bp[3]  = '{2'b11, 16'h0001, 16'h0000, 7'h02, 16'h0000, 3'b000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_mode = 2'b00; in_a = '0; in_b = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, '0);
    check("rst_out_nzp", out_nzp, 3'b000);
    check("rst_done_count", done_count, '0);
    check("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].imm, w);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("tbl%0d_result", i), out_result, tbl[i].res);
      check($sformatf("tbl%0d_nzp", i), out_nzp, tbl[i].nzp);
      @(posedge clk);
      #1;
    end
    wait_idle();

    do_reset();
    lat_log.delete();
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      send_rand(w);
      wsum += w;
    end
    wait_idle();
    check("stream_stalls", wsum, 0);
    check("stream_count", lat_log.size(), 8);
    nbad = 0;
    foreach (lat_log[i]) if (lat_log[i] != 2) nbad++;
    check("stream_latency", nbad, 0);
    check("stream_done_count", done_count, 8);

    out_ready = 1'b0;
    base = n_out;
    idx  = 0;
    held = '0;
    rdy_log = '0;
    for (int c = 0; c < 4; c++) begin
      in_mode = bp[idx].m; in_a = bp[idx].a; in_b = bp[idx].b; in_imm = bp[idx].imm;
      in_valid = 1'b1;
      @(negedge clk);
      rdy_log[c] = in_ready;
      if (c == 2) begin
        check("bp_out_valid", out_valid, 1'b1);
        held = out_result;
      end
      if (c == 3) check("bp_hold_result", out_result, held);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    check("bp_accepted", idx, 2);
    check("bp_ready_pattern", rdy_log, 4'b0011);
    out_ready = 1'b1;
    send(bp[2].m, bp[2].a, bp[2].b, bp[2].imm, w);
    send(bp[3].m, bp[3].a, bp[3].b, bp[3].imm, w);
    wait_idle();
    check("bp_drained", n_out - base, 4);

    out_ready = 1'b0;
    send(2'b00, 16'h0001, 16'h0002, 7'h00, w);
    send(2'b01, 16'h0005, 16'h0002, 7'h00, w);
    @(negedge clk);
    check("mid_pre_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    in_mode = 2'b00; in_a = 16'h0009; in_b = 16'h0001;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_out_valid", out_valid, 1'b0);
    check("mid_out_result", out_result, '0);
    check("mid_out_nzp", out_nzp, 3'b000);
    check("mid_done_count", done_count, '0);
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("mid_no_stale", cnt, 0);
    @(posedge clk);
    #1;

    do_reset();
    base = n_out;
    for (int i = 0; i < 255; i++) send_rand(w);
    wait_idle();
    check("sat_at_255", done_count, 255);
    for (int i = 0; i < 45; i++) send_rand(w);
    wait_idle();
    check("sat_after_300", done_count, 255);
    check("sat_total_out", n_out - base, 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
